// File: rtl/pipe_ctrl_v2.sv
// rtl/pipe_ctrl_v2.sv - pipeline stall merge, exception flush/redirect and stall-cycle counter
module pipe_ctrl_v2 #(
    parameter int unsigned STAGES = 10,
    parameter int unsigned NREQ = 5,
    parameter logic [NREQ*STAGES-1:0] STALL_MASKS = {10'h00F, 10'h01F, 10'h1FF, 10'h1FF, 10'h1FF},
    parameter logic [31:0] EXC_VEC = 32'hbfc00380,
    parameter logic [31:0] ALT_VEC = 32'hbfc00200,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic [31:0]       current_pc,
    input  logic              pc_ready_i,
    input  logic              cnt_clr_i,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [31:0]       new_pc,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t            state, state_nx;
    logic [31:0]       pend_pc;
    logic [31:0]       target;
    logic              pend_load;
    logic [STAGES-1:0] req_stall;
    logic [CNT_W-1:0]  cnt;

    always_comb begin
        target = '0;
        case (excepttype_i)
            32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd,
            32'h12, 32'h14, 32'h15: target = EXC_VEC;
            32'he:                  target = cp0_epc_i;
            32'h11, 32'h13:         target = ALT_VEC;
            32'hffffffff:           target = current_pc + 32'd4;
            default:                target = '0;
        endcase
    end

    always_comb begin
        req_stall = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (stallreq_i[k]) req_stall = req_stall | STALL_MASKS[k*STAGES +: STAGES];
        end
    end

    // Everything stays zero while in reset; an exception in IDLE overrides all stall requests.
    always_comb begin
        state_nx       = state;
        stall          = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        new_pc         = '0;
        pend_load      = 1'b0;
        if (resetn) begin
            case (state)
                IDLE: begin
                    if (excepttype_i != 32'h0) begin
                        flush          = 1'b1;
                        redirect_valid = 1'b1;
                        new_pc         = target;
                        if (!pc_ready_i) begin
                            pend_load = 1'b1;
                            state_nx  = PEND;
                        end
                    end else begin
                        stall = req_stall;
                    end
                end
                PEND: begin
                    redirect_valid = 1'b1;
                    new_pc         = pend_pc;
                    stall          = req_stall;
                    if (pc_ready_i) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            pend_pc <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (pend_load) pend_pc <= target;
            if (cnt_clr_i) cnt <= '0;
            else if ((stall != '0) && !(&cnt)) cnt <= cnt + CNT_W'(1);
        end
    end

    assign stall_cycles_o = resetn ? cnt : '0;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// tb/tb_pipe_ctrl_v2.sv - directed bench for pipe_ctrl_v2 (default build plus 4-bit counter build)
module tb_pipe_ctrl_v2;

    logic        clk;
    logic        resetn;
    logic [4:0]  stallreq_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [31:0] current_pc;
    logic        pc_ready_i;
    logic        cnt_clr_i;

    logic [9:0]  stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles_o;

    logic [9:0]  stall4;
    logic        flush4;
    logic        redirect_valid4;
    logic [31:0] new_pc4;
    logic [3:0]  stall_cycles4;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_ctrl_v2 dut (
        .clk(clk), .resetn(resetn), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
        .cp0_epc_i(cp0_epc_i), .current_pc(current_pc), .pc_ready_i(pc_ready_i),
        .cnt_clr_i(cnt_clr_i), .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
        .new_pc(new_pc), .stall_cycles_o(stall_cycles_o)
    );

    pipe_ctrl_v2 #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
        .cp0_epc_i(cp0_epc_i), .current_pc(current_pc), .pc_ready_i(pc_ready_i),
        .cnt_clr_i(cnt_clr_i), .stall(stall4), .flush(flush4), .redirect_valid(redirect_valid4),
        .new_pc(new_pc4), .stall_cycles_o(stall_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn       = 1'b0;
        stallreq_i   = 5'h1F;
        excepttype_i = 32'h1;
        cp0_epc_i    = 32'h0;
        current_pc   = 32'h0;
        pc_ready_i   = 1'b0;
        cnt_clr_i    = 1'b0;

        // 1: reset forces outputs low
        tick();
        check("rst_stall", stall, 10'h0);
        check("rst_flush", flush, 1'b0);
        check("rst_rv", redirect_valid, 1'b0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_cnt", stall_cycles_o, 32'h0);
        tick();
        resetn       = 1'b1;
        stallreq_i   = 5'h0;
        excepttype_i = 32'h0;
        #1;
        check("rel_stall", stall, 10'h0);
        check("rel_cnt", stall_cycles_o, 32'h0);
        tick();

        // 2: stall mask merge and counter
        stallreq_i = 5'b11000;
        #1;
        check("mask_ex_load", stall, 10'h01F);
        tick();
        check("cnt_1", stall_cycles_o, 32'd1);
        stallreq_i = 5'b10000;
        #1;
        check("mask_load", stall, 10'h00F);
        tick();
        stallreq_i = 5'b00001;
        #1;
        check("mask_icache", stall, 10'h1FF);
        tick();
        stallreq_i = 5'b0;
        #1;
        check("cnt_3", stall_cycles_o, 32'd3);
        check("cnt4_3", stall_cycles4, 4'd3);

        // 3: exception with immediate accept beats stall requests
        excepttype_i = 32'h8;
        pc_ready_i   = 1'b1;
        stallreq_i   = 5'h1F;
        #1;
        check("exc8_flush", flush, 1'b1);
        check("exc8_stall", stall, 10'h0);
        check("exc8_rv", redirect_valid, 1'b1);
        check("exc8_pc", new_pc, 32'hbfc00380);
        tick();
        excepttype_i = 32'h0;
        pc_ready_i   = 1'b0;
        stallreq_i   = 5'h0;
        #1;
        check("exc8_after_flush", flush, 1'b0);
        check("exc8_after_rv", redirect_valid, 1'b0);
        check("exc8_cnt_hold", stall_cycles_o, 32'd3);

        // 4: eret held pending until fetch accepts
        excepttype_i = 32'he;
        cp0_epc_i    = 32'h80001234;
        #1;
        check("eret_c0_flush", flush, 1'b1);
        check("eret_c0_pc", new_pc, 32'h80001234);
        tick();
        excepttype_i = 32'h4;
        cp0_epc_i    = 32'h0;
        #1;
        check("pend_c1_flush", flush, 1'b0);
        check("pend_c1_rv", redirect_valid, 1'b1);
        check("pend_c1_pc", new_pc, 32'h80001234);
        tick();
        excepttype_i = 32'h0;
        stallreq_i   = 5'b01000;
        #1;
        check("pend_c2_flush", flush, 1'b0);
        check("pend_c2_pc", new_pc, 32'h80001234);
        check("pend_c2_stall", stall, 10'h01F);
        tick();
        stallreq_i = 5'b0;
        pc_ready_i = 1'b1;
        #1;
        check("pend_accept_rv", redirect_valid, 1'b1);
        check("pend_accept_pc", new_pc, 32'h80001234);
        check("pend_cnt_4", stall_cycles_o, 32'd4);
        tick();
        pc_ready_i = 1'b0;
        #1;
        check("idle_again_rv", redirect_valid, 1'b0);
        check("idle_again_pc", new_pc, 32'h0);

        // 5: target decode corners (accepted immediately)
        pc_ready_i   = 1'b1;
        excepttype_i = 32'hffffffff;
        current_pc   = 32'hfffffffc;
        #1;
        check("refetch_wrap", new_pc, 32'h0);
        current_pc = 32'h00001000;
        #1;
        check("refetch", new_pc, 32'h00001004);
        excepttype_i = 32'h13;
        #1;
        check("alt_13", new_pc, 32'hbfc00200);
        excepttype_i = 32'h11;
        #1;
        check("alt_11", new_pc, 32'hbfc00200);
        excepttype_i = 32'h15;
        #1;
        check("exc_15", new_pc, 32'hbfc00380);
        excepttype_i = 32'h7;
        #1;
        check("unk_7_pc", new_pc, 32'h0);
        check("unk_7_flush", flush, 1'b1);
        tick();
        excepttype_i = 32'h0;
        pc_ready_i   = 1'b0;
        #1;
        check("decode_idle", redirect_valid, 1'b0);

        // 6: saturation, clear priority, reset mid-PEND
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        #1;
        check("clr_cnt", stall_cycles_o, 32'h0);
        check("clr_cnt4", stall_cycles4, 4'h0);
        stallreq_i = 5'b00001;
        for (int i = 0; i < 14; i++) tick();
        check("cnt4_14", stall_cycles4, 4'hE);
        tick();
        check("cnt4_15", stall_cycles4, 4'hF);
        for (int i = 0; i < 3; i++) tick();
        check("cnt4_sat", stall_cycles4, 4'hF);
        check("cnt_18", stall_cycles_o, 32'd18);
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i  = 1'b0;
        stallreq_i = 5'b0;
        #1;
        check("clr_over_inc", stall_cycles_o, 32'h0);
        check("clr_over_inc4", stall_cycles4, 4'h0);

        excepttype_i = 32'h1;
        tick();
        excepttype_i = 32'h0;
        #1;
        check("pend_before_rst_rv", redirect_valid, 1'b1);
        check("pend_before_rst_pc", new_pc, 32'hbfc00380);
        resetn = 1'b0;
        #1;
        check("rst_in_pend_rv", redirect_valid, 1'b0);
        tick();
        resetn = 1'b1;
        #1;
        check("post_rst_rv", redirect_valid, 1'b0);
        check("post_rst_pc", new_pc, 32'h0);
        tick();
        check("post_rst_idle", redirect_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_v2.md
Name: pipe_ctrl_v2

Overview:
Parametrised pipeline control unit for the single-issue MIPS core. It merges any number of stall-request sources into a per-stage stall vector using per-source masks. It decodes the exception type into a flush and a redirect PC. Unlike the previous control unit, it holds a pending redirect until the fetch stage accepts it, and it keeps a saturating stall-cycle performance counter.

Parameters:
STAGES, 10, width of stall vector; bit i freezes pipeline stage i (bit 0 = PC).
NREQ, 5, number of stall-request sources.
STALL_MASKS, {10'h0ff? no: see default below}, packed NREQ*STAGES masks. Source k uses bits [k*STAGES +: STAGES]. Default, for k = 0..4: 0x1FF, 0x1FF, 0x1FF, 0x01F, 0x00F (icache, dcache, uncache, ex, load).
EXC_VEC, 32'hbfc00380, general exception vector.
ALT_VEC, 32'hbfc00200, vector for codes 0x11 and 0x13.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  core clock.
resetn  in  1  synchronous reset, active-low.
stallreq_i  in  NREQ  stall requests; bit k = source k.
excepttype_i  in  32  exception code from MEM/WB; 0 = none.
cp0_epc_i  in  32  EPC for eret.
current_pc  in  32  PC of the excepting instruction.
pc_ready_i  in  1  fetch stage accepts a redirect this cycle.
cnt_clr_i  in  1  clear the stall counter.
stall  out  STAGES  per-stage stall vector.
flush  out  1  one-cycle pipeline flush.
redirect_valid  out  1  new_pc is valid.
new_pc  out  32  redirect target.
stall_cycles_o  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low.
  - While resetn=0: all outputs are forced to 0 combinationally.
  - At the clock edge: state<=IDLE, pend_pc<=0, counter<=0.
- Target decode (combinational):
  - Codes 0x1, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc, 0xd, 0x12, 0x14, 0x15 -> EXC_VEC.
  - 0xe (eret) -> cp0_epc_i.
  - 0x11, 0x13 -> ALT_VEC.
  - 0xffffffff (refetch) -> current_pc+4, wrapping mod 2^32.
  - Any other nonzero code -> 0.
- FSM states: IDLE, PEND.
- IDLE, excepttype_i != 0:
  - flush=1, redirect_valid=1, new_pc=target, stall=0. This takes priority over all stall requests.
  - If pc_ready_i=1: stay IDLE.
  - Else: pend_pc<=target and go to PEND.
- IDLE, excepttype_i == 0:
  - flush=0, redirect_valid=0, new_pc=0.
  - stall = bitwise OR of STALL_MASKS[k] over all asserted stallreq_i[k].
- PEND:
  - flush=0, redirect_valid=1, new_pc=pend_pc.
  - stall = OR of the masks, as in IDLE.
  - excepttype_i is ignored, because the pipeline is already flushed.
  - pc_ready_i=1 -> go to IDLE next cycle. The redirect is consumed in this same cycle.
- Flush timing: flush is exactly one cycle per exception and is never reasserted in PEND.
- Stall counter:
  - Increments on each clock where stall != 0 and resetn=1.
  - Saturates at all-ones.
  - cnt_clr_i=1 sets it to 0 and overrides the increment in the same cycle.
  - Flush cycles do not count (stall=0 in those cycles).
- Reset mid-PEND: the pending redirect is dropped and the state returns to IDLE.
- Latency: flush, stall and the first new_pc are combinational (0 cycles). pend_pc is registered (new_pc visible in PEND from the next cycle).

Test Plan:
1. resetn=0 with stallreq_i=5'h1F and excepttype_i=1 -> all outputs 0. After release with all inputs 0 -> stall=0 and stall_cycles_o=0.
2. stallreq_i=5'b11000 -> stall=0x01F. stallreq_i=5'b10000 -> stall=0x00F. stallreq_i=5'b00001 -> stall=0x1FF. The counter increments by 1 per cycle across these 3 cycles (reads 3).
3. excepttype_i=0x8 with pc_ready_i=1 and stallreq_i=5'h1F -> flush=1, stall=0, new_pc=0xbfc00380 for one cycle, then state stays IDLE.
4. excepttype_i=0xe, cp0_epc_i=0x80001234, pc_ready_i=0 for 3 cycles:
   - Cycle 0: flush=1.
   - Cycles 1-2: flush=0, redirect_valid=1, new_pc=0x80001234.
   - Raise pc_ready_i -> IDLE next cycle.
   - An exception code 0x4 injected during PEND does not change new_pc.
5. excepttype_i=0xffffffff with current_pc=0xfffffffc -> new_pc=0x00000000. excepttype_i=0x13 -> new_pc=0xbfc00200. excepttype_i=0x7 -> new_pc=0.
6. Counter preset near saturation (CNT_W=4 build) with continuous stall -> holds at 0xF. Asserting cnt_clr_i together with stall -> 0 next cycle. Driving resetn=0 during PEND -> IDLE, redirect_valid=0.
